// File: rtl/ex_operand_fwd.sv
// Execute-stage operand forwarding (MEM > WB > RF) per channel into a 1-cycle stage register.
// No backpressure: stall holds the register (still snooping WB), flush inserts a bubble.
module ex_operand_fwd #(
  parameter int XLEN = 32,
  parameter int NCH  = 2,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [NCH*AW-1:0]    rs_addr,
  input  logic [NCH*XLEN-1:0]  rf_data,
  input  logic                 mem_we,
  input  logic [AW-1:0]        mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  output logic [NCH*XLEN-1:0]  op_data,
  output logic [NCH*2-1:0]     fwd_sel,
  output logic [15:0]          fwd_count
);

  logic [NCH*2-1:0]    sel_c;
  logic [NCH*XLEN-1:0] opnd_c;
  logic [2:0]          nfwd;
  logic [16:0]         cnt_sum;
  logic [NCH*AW-1:0]   rs_q;

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    sel_c  = '0;
    opnd_c = '0;
    nfwd   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (mem_we && (mem_rd != '0) && (mem_rd == rs_addr[k*AW +: AW]))
        sel_c[k*2 +: 2] = 2'd2;
      else if (wb_we && (wb_rd != '0) && (wb_rd == rs_addr[k*AW +: AW]))
        sel_c[k*2 +: 2] = 2'd1;
      else
        sel_c[k*2 +: 2] = 2'd0;

      case (sel_c[k*2 +: 2])
        2'd0:    opnd_c[k*XLEN +: XLEN] = rf_data[k*XLEN +: XLEN];
        2'd1:    opnd_c[k*XLEN +: XLEN] = wb_data;
        2'd2:    opnd_c[k*XLEN +: XLEN] = mem_data;
        default: opnd_c[k*XLEN +: XLEN] = '0;
      endcase

      if (sel_c[k*2 +: 2] != 2'd0)
        nfwd = nfwd + 3'd1;
    end
  end

  assign cnt_sum = {1'b0, fwd_count} + {14'd0, nfwd};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      op_data   <= '0;
      fwd_sel   <= '0;
      rs_q      <= '0;
      fwd_count <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        op_data   <= '0;
        fwd_sel   <= '0;
        rs_q      <= '0;
      end else if (stall) begin
        // Held operands track WB writebacks so they are current when the stall releases.
        for (int k = 0; k < NCH; k++) begin
          if (wb_we && (rs_q[k*AW +: AW] != '0) && (wb_rd == rs_q[k*AW +: AW]))
            op_data[k*XLEN +: XLEN] <= wb_data;
        end
      end else begin
        out_valid <= in_valid;
        op_data   <= opnd_c;
        fwd_sel   <= sel_c;
        rs_q      <= rs_addr;
        if (in_valid)
          fwd_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_fwd.sv
// Scoreboard bench for ex_operand_fwd: reference model predicts each edge, results compared 1 cycle later.
module tb_ex_operand_fwd;
  localparam int XLEN = 32;
  localparam int NCH  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, stall, flush, in_valid;
  logic [NCH*AW-1:0]   rs_addr;
  logic [NCH*XLEN-1:0] rf_data;
  logic                mem_we, wb_we;
  logic [AW-1:0]       mem_rd, wb_rd;
  logic [XLEN-1:0]     mem_data, wb_data;
  logic                out_valid;
  logic [NCH*XLEN-1:0] op_data;
  logic [NCH*2-1:0]    fwd_sel;
  logic [15:0]         fwd_count;

  ex_operand_fwd #(.XLEN(XLEN), .NCH(NCH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rs_addr(rs_addr), .rf_data(rf_data),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .op_data(op_data), .fwd_sel(fwd_sel), .fwd_count(fwd_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic                v;
    logic [NCH*XLEN-1:0] op;
    logic [NCH*2-1:0]    sel;
    logic [15:0]         cnt;
  } exp_t;
  exp_t q[$];

  // Reference model state
  logic            m_v;
  logic [XLEN-1:0] m_op[NCH];
  logic [1:0]      m_sel[NCH];
  logic [AW-1:0]   m_rs[NCH];
  int              m_cnt;

  function automatic logic [1:0] pick(input logic [AW-1:0] r);
    if (r == 0) return 2'd0;
    if (mem_we && mem_rd == r) return 2'd2;
    if (wb_we && wb_rd == r) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_edge();
    int hits;
    logic [AW-1:0] r;
    hits = 0;
    if (rst || flush) begin
      m_v = 1'b0;
      for (int k = 0; k < NCH; k++) begin m_op[k] = '0; m_sel[k] = '0; m_rs[k] = '0; end
      if (rst) m_cnt = 0;
    end else if (stall) begin
      for (int k = 0; k < NCH; k++)
        if (m_rs[k] != 0 && wb_we && wb_rd == m_rs[k]) m_op[k] = wb_data;
    end else begin
      m_v = in_valid;
      for (int k = 0; k < NCH; k++) begin
        r = rs_addr[k*AW +: AW];
        m_sel[k] = pick(r);
        m_rs[k]  = r;
        if (m_sel[k] == 2'd2)      m_op[k] = mem_data;
        else if (m_sel[k] == 2'd1) m_op[k] = wb_data;
        else                       m_op[k] = rf_data[k*XLEN +: XLEN];
        if (m_sel[k] != 2'd0) hits++;
      end
      if (in_valid) m_cnt = (m_cnt + hits > 65535) ? 65535 : m_cnt + hits;
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.v   = m_v;
    e.cnt = m_cnt[15:0];
    for (int k = 0; k < NCH; k++) begin
      e.op[k*XLEN +: XLEN] = m_op[k];
      e.sel[k*2 +: 2]      = m_sel[k];
    end
    return e;
  endfunction

  task automatic step(input bit do_chk);
    exp_t e;
    model_edge();
    if (do_chk) q.push_back(snap());
    @(posedge clk);
    #1;
    if (do_chk && q.size() != 0) begin
      e = q.pop_front();
      chk("out_valid", 64'(out_valid), 64'(e.v));
      chk("op_data",   64'(op_data),   64'(e.op));
      chk("fwd_sel",   64'(fwd_sel),   64'(e.sel));
      chk("fwd_count", 64'(fwd_count), 64'(e.cnt));
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; in_valid = 0;
    rs_addr = '0; rf_data = '0;
    mem_we = 0; mem_rd = '0; mem_data = '0;
    wb_we = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic rand_in();
    stall    = ($urandom_range(0, 3) == 0);
    flush    = ($urandom_range(0, 7) == 0);
    in_valid = $urandom_range(0, 1);
    for (int k = 0; k < NCH; k++) rs_addr[k*AW +: AW] = AW'($urandom_range(0, 3));
    rf_data  = {$urandom, $urandom};
    mem_we   = $urandom_range(0, 1);
    mem_rd   = AW'($urandom_range(0, 3));
    mem_data = $urandom;
    wb_we    = $urandom_range(0, 1);
    wb_rd    = AW'($urandom_range(0, 3));
    wb_data  = $urandom;
  endtask

  initial begin
    idle();
    m_v = 0; m_cnt = 0;
    for (int k = 0; k < NCH; k++) begin m_op[k] = '0; m_sel[k] = '0; m_rs[k] = '0; end

    // Reset held two cycles under random inputs
    for (int i = 0; i < 2; i++) begin
      rand_in();
      rst = 1;
      step(1);
    end
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt",   64'(fwd_count), 64'd0);

    // MEM beats WB on the same register
    idle();
    in_valid = 1; rs_addr = {5'd5, 5'd5};
    mem_we = 1; mem_rd = 5; mem_data = 32'hAAAA0000;
    wb_we = 1;  wb_rd = 5;  wb_data = 32'h5555;
    step(1);
    chk("prio_op",  64'(op_data),   {32'hAAAA0000, 32'hAAAA0000});
    chk("prio_sel", 64'(fwd_sel),   64'hA);
    chk("prio_cnt", 64'(fwd_count), 64'd2);

    // x0 never forwarded even when MEM writes rd=0
    idle();
    in_valid = 1; rs_addr = {5'd0, 5'd3}; rf_data = {32'h0, 32'h9999};
    mem_we = 1; mem_rd = 0; mem_data = 32'hDEAD;
    wb_we = 1;  wb_rd = 3;  wb_data = 32'h1234;
    step(1);
    chk("x0_op",  64'(op_data),   {32'h0, 32'h1234});
    chk("x0_sel", 64'(fwd_sel),   64'h1);
    chk("x0_cnt", 64'(fwd_count), 64'd3);

    // Stall snoop: WB updates the held operand, MEM is ignored
    idle();
    in_valid = 1; rs_addr = {5'd7, 5'd8}; rf_data = {32'h11, 32'h22};
    step(1);
    for (int c = 0; c < 3; c++) begin
      idle();
      stall = 1; in_valid = 1; rs_addr = {5'd9, 5'd9}; rf_data = {32'h77, 32'h66};
      if (c == 1) begin
        wb_we = 1; wb_rd = 8; wb_data = 32'hBEEF;
        mem_we = 1; mem_rd = 7; mem_data = 32'hCAFE;
      end
      step(1);
    end
    chk("snoop_op",  64'(op_data),   {32'h11, 32'hBEEF});
    chk("snoop_sel", 64'(fwd_sel),   64'h0);
    chk("snoop_vld", 64'(out_valid), 64'd1);

    // Flush wins over stall, then a normal load
    idle();
    stall = 1; flush = 1;
    step(1);
    chk("flush_vld", 64'(out_valid), 64'd0);
    chk("flush_op",  64'(op_data),   64'd0);
    idle();
    in_valid = 1; rs_addr = {5'd2, 5'd4}; rf_data = {32'h42, 32'h43};
    wb_we = 1; wb_rd = 4; wb_data = 32'h99;
    step(1);
    chk("post_flush_op", 64'(op_data), {32'h42, 32'h99});

    // Random traffic including resets mid-stall
    for (int i = 0; i < 400; i++) begin
      rand_in();
      rst = ($urandom_range(0, 39) == 0);
      step(1);
    end

    // Saturation of fwd_count
    idle();
    rst = 1;
    step(1);
    idle();
    in_valid = 1; rs_addr = {5'd5, 5'd5};
    mem_we = 1; mem_rd = 5; mem_data = 32'h1;
    for (int i = 0; i < 32767; i++) step(0);
    chk("sat_pre", 64'(fwd_count), 64'hFFFE);
    step(1);
    chk("sat_hit", 64'(fwd_count), 64'hFFFF);
    for (int i = 0; i < 3; i++) step(1);
    chk("sat_hold", 64'(fwd_count), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_operand_fwd.md
# ex_operand_fwd

Parametrised successor to the execute-stage 3:1 operand-forwarding multiplexer. The block sits at the ID→EX boundary: for each of NCH source-operand channels it resolves forwarding from the MEM and WB stages against the register-file value. It captures the result in a pipeline register with stall and flush control. While stalled, it keeps snooping WB writebacks so a held operand never goes stale.

## Interface
- XLEN, 32, operand data width
- NCH, 2, number of operand channels (1..4)
- AW, 5, register-address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold the stage register; no new load
- flush  in  1  invalidate the stage register (bubble)
- in_valid  in  1  decode stage presents a valid instruction
- rs_addr  in  NCH*AW  source register address per channel; channel k at [k*AW +: AW]
- rf_data  in  NCH*XLEN  register-file read data per channel
- mem_we, mem_rd, mem_data  in  1, AW, XLEN  MEM-stage write enable, destination, result
- wb_we, wb_rd, wb_data  in  1, AW, XLEN  WB-stage write enable, destination, result
- out_valid  out  1  stage register holds a valid instruction
- op_data  out  NCH*XLEN  registered operand per channel
- fwd_sel  out  NCH*2  registered select used per channel: 0=RF, 1=WB, 2=MEM, 3=illegal/never produced
- fwd_count  out  16  saturating count of forwarded operands

## Operation
- Select per channel k (combinational, before the register), using r = rs_addr[k]:
  - 2 if mem_we && mem_rd!=0 && mem_rd==r
  - else 1 if wb_we && wb_rd!=0 && wb_rd==r
  - else 0
- Operand per channel: sel 0→rf_data[k], 1→wb_data, 2→mem_data, 3→all zeros.
- MEM has priority over WB because it is the younger producer.
- Register x0 is never forwarded: r==0 always gives sel 0 and takes rf_data unchanged.
- Register update priority on each edge: rst > flush > stall > load.
  - rst: out_valid=0, op_data=0, fwd_sel=0, fwd_count=0.
  - flush (stall ignored): out_valid=0. op_data, fwd_sel and the held rs_addr are cleared to 0.
  - stall, no flush: out_valid and fwd_sel are held. For each channel with held address h!=0 and wb_we && wb_rd==h, op_data[k] ← wb_data; other channels hold. MEM is not snooped during stall.
  - load (no stall/flush): out_valid ← in_valid. op_data, fwd_sel and the held rs_addr are loaded from the combinational result, regardless of in_valid.
- fwd_count increments on a load with in_valid=1 by the number of channels with sel≠0 (0..NCH). It saturates at 16'hFFFF and is unaffected by stall or flush.
- The block stores the held rs_addr per channel internally (NCH*AW flops) for stall snooping.

## Timing
- Latency: 1 cycle from decode inputs to op_data/fwd_sel/out_valid.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Stall snoop update is visible the cycle after the WB write.
- Simultaneous stall+flush → flush wins.
- Simultaneous rst with anything → reset values.
- Reset asserted mid-stall discards the held instruction; the first load after rst deasserts behaves normally.
- A stall snoop and a load never occur in the same cycle, because they are mutually exclusive by priority.

## Test plan
- Reset: hold rst 2 cycles with random inputs → out_valid=0, op_data=0, fwd_sel=0, fwd_count=0.
- Priority: NCH=2, rs_addr={5,5}, mem_we=1 mem_rd=5 mem_data=0xAAAA0000, wb_we=1 wb_rd=5 wb_data=0x5555, in_valid=1 → next cycle both op_data=0xAAAA0000, fwd_sel={2,2}, fwd_count=2.
- x0 guard: rs_addr={0,3}, mem_rd=0 mem_we=1, wb_rd=3 wb_we=1 wb_data=0x1234, rf_data={0x0,0x9999} → op_data={0x0,0x1234}, fwd_sel={0,1}, fwd_count+=1.
- Stall snoop: load rs={7,8} from RF (0x11, 0x22). Stall for 3 cycles; in stall cycle 2 pulse wb_we=1 wb_rd=8 wb_data=0xBEEF → op_data={0x11,0xBEEF} from the following cycle. Same-cycle mem_rd=7 has no effect. fwd_sel stays {0,0}.
- Flush vs stall: stall=1 flush=1 with out_valid=1 → out_valid=0, op_data=0. Next cycle stall=0, in_valid=1 → normal load.
- Saturation: preload fwd_count to 0xFFFE via 32767 double-forward loads, then one more double-forward load → 0xFFFF, and it stays 0xFFFF on further forwarding loads.
